// File: rtl/ex_operand_stage.sv
// ID/EX stage register with EX-side operand forwarding, load-use hazard detection and a saturating stall counter.
// One cycle from capture to EX. stall_if_id asks upstream to hold IF/ID while a bubble is inserted.
module ex_operand_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rdata1,
  input  logic [XLEN-1:0] id_rdata2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alusrc,
  input  logic [2:0]      id_aluop,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_branch,
  input  logic            flush,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_aluresult,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            stall_if_id,
  output logic            ex_valid,
  output logic [2:0]      ex_aluop,
  output logic [XLEN-1:0] ex_in1,
  output logic [XLEN-1:0] ex_in2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic [31:0]     stall_count
);

  logic            valid_q, valid_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic            alusrc_q, alusrc_d;
  logic [2:0]      aluop_q, aluop_d;
  logic            regwrite_q, regwrite_d, memread_q, memread_d;
  logic            memwrite_q, memwrite_d, branch_q, branch_d;
  logic [31:0]     stall_count_q, stall_count_d;

  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    hazard = valid_q & memread_q & (rd_q != 5'd0) & id_valid &
             ((rd_q == id_rs1) | ((rd_q == id_rs2) & (~id_alusrc | id_memwrite)));
    stall_if_id = hazard & ~flush;
    capture = id_valid & ~flush & ~hazard;
  end

  // Anything other than a clean capture loads an all-zero bubble.
  always_comb begin
    valid_d    = 1'b0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    rdata1_d   = '0;
    rdata2_d   = '0;
    imm_d      = '0;
    alusrc_d   = 1'b0;
    aluop_d    = '0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    branch_d   = 1'b0;
    if (capture) begin
      valid_d    = 1'b1;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      aluop_d    = id_aluop;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
      branch_d   = id_branch;
      // Write-through so the register file needs no write-before-read.
      rdata1_d = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_wdata : id_rdata1;
      rdata2_d = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_wdata : id_rdata2;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_if_id && stall_count_q != 32'hFFFF_FFFF) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      rdata1_q      <= '0;
      rdata2_q      <= '0;
      imm_q         <= '0;
      alusrc_q      <= 1'b0;
      aluop_q       <= '0;
      regwrite_q    <= 1'b0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      branch_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      rdata1_q      <= rdata1_d;
      rdata2_q      <= rdata2_d;
      imm_q         <= imm_d;
      alusrc_q      <= alusrc_d;
      aluop_q       <= aluop_d;
      regwrite_q    <= regwrite_d;
      memread_q     <= memread_d;
      memwrite_q    <= memwrite_d;
      branch_q      <= branch_d;
      stall_count_q <= stall_count_d;
    end
  end

  // MEM beats WB; x0 is never forwarded.
  always_comb begin
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs1_q)     fwd_rs1 = mem_aluresult;
    else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs1_q)   fwd_rs1 = wb_wdata;
    else                                                       fwd_rs1 = rdata1_q;
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs2_q)     fwd_rs2 = mem_aluresult;
    else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs2_q)   fwd_rs2 = wb_wdata;
    else                                                       fwd_rs2 = rdata2_q;
  end

  assign ex_valid      = valid_q;
  assign ex_aluop      = aluop_q;
  assign ex_in1        = fwd_rs1;
  assign ex_in2        = alusrc_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_branch     = branch_q;
  assign stall_count   = stall_count_q;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline boundary for the 64-bit RISC-V pipelined core. Registers the decoded instruction and produces the ALU's `ALUOp`, `in1` and `in2` inputs, with EX/MEM and MEM/WB operand forwarding. It also detects load-use hazards, requests an IF/ID stall and inserts a bubble. A saturating counter records the number of load-use stall cycles.

## Interface
- XLEN, 64, datapath width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2, id_rd  in  5 each  register specifiers
- id_rdata1, id_rdata2  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alusrc  in  1  1: in2 = immediate
- id_aluop  in  3  ALU code: 000 and, 001 or, 010 add, 011 sub, 100 slt, 101 xor, 110 addi
- id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  control bits
- flush  in  1  squash the instruction entering EX
- mem_regwrite  in  1,  mem_rd  in  5,  mem_aluresult  in  XLEN  EX/MEM forward source
- wb_regwrite  in  1,  wb_rd  in  5,  wb_wdata  in  XLEN  MEM/WB forward source
- stall_if_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX slot valid
- ex_aluop  out  3,  ex_in1, ex_in2  out  XLEN  ALU inputs
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_rd  out  5;  ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each
- stall_count  out  32  load-use stall cycles, saturating

## Operation
- **Stage registers.** The stage holds valid, rs1, rs2, rd, rdata1, rdata2, imm, alusrc, aluop and the four control bits. All of these load every cycle; there is no downstream hold.
- **Bubble.** A bubble loads 0 into every stage register. As a result, ex_valid=0, all control bits are 0, ex_aluop=000 and ex_in1 = ex_in2 = ex_store_data = 0.
- **Load priority** (highest first): reset → all zero; flush → bubble; hazard → bubble; otherwise capture the id_* inputs. If id_valid=0, capture is a bubble.
- **ID-side write-through.** At capture, a captured rdataN is replaced by wb_wdata when all of the following hold: wb_regwrite=1, wb_rd≠0 and wb_rd==id_rsN. The register file therefore needs no write-before-read behaviour.
- **EX-side forwarding.** Forwarding is combinational and operates on the registered values. For each of rs1 and rs2:
  - If mem_regwrite=1, mem_rd≠0 and mem_rd==rsN: use mem_aluresult.
  - Else if wb_regwrite=1, wb_rd≠0 and wb_rd==rsN: use wb_wdata.
  - Else use the registered rdataN.
  - MEM has priority over WB. x0 is never forwarded.
- **Operand outputs.**
  - ex_in1 = fwd_rs1.
  - ex_in2 = imm if alusrc=1, else fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- **Hazard detection.**
  - hazard = ex_valid & ex_memread & (ex_rd≠0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2 & (~id_alusrc | id_memwrite))).
  - stall_if_id = hazard & ~flush. This is combinational from the stage registers and the id_* inputs.
- **Stall counter.** stall_count increments by 1 on each edge where stall_if_id=1. It holds at 0xFFFFFFFF once it reaches that value. reset clears it to 0.

## Timing
- Capture-to-EX latency: 1 cycle. Forwarding adds no latency.
- Reset value of every output is 0. This includes stall_if_id, which is 0 after reset because the registered ex_memread is 0.
- **Load-use sequence.**
  - Cycle N: stall_if_id=1. Upstream must hold the id_* inputs stable.
  - Edge N+1: a bubble enters EX. The dependent instruction remains in ID.
  - Cycle N+1: no hazard, because EX now holds the bubble. The dependent instruction is captured at edge N+2.
  - During N+2, the load is in WB and is forwarded through the wb path.
- **flush and hazard in the same cycle:** the bubble is inserted, stall_if_id=0 and stall_count is unchanged.
- **reset asserted mid-stream:** at the next edge, every register and stall_count is cleared regardless of flush or hazard.
- **Double match** (same rd in MEM and WB): the MEM value is used.
- **Write-through and MEM forward both apply to the same register:** the EX-side MEM forward overrides the captured write-through value.

## Test plan
- **Reset mid-stream:** set stall_count=5 and ex_valid=1, then assert reset for 1 cycle → next cycle every output is 0 and stall_count=0.
- **Forward priority:** EX holds rs1=5. Drive mem_regwrite=1, mem_rd=5, mem_aluresult=0x10 and wb_regwrite=1, wb_rd=5, wb_wdata=0x20 → ex_in1=0x10. Drop mem_regwrite → ex_in1=0x20.
- **x0 never forwarded:** EX holds rs1=0 with captured rdata1=0. Drive mem_regwrite=1, mem_rd=0, mem_aluresult=0xFFFF → ex_in1=0.
- **Load-use:** EX holds ld with rd=7. ID holds add with rs2=7, alusrc=0 → stall_if_id=1. Next cycle: ex_valid=0 and stall_count=1. Following cycle: add is in EX. With wb_rd=7, wb_wdata=0x1234 → ex_in2=0x1234.
- **Write-through and immediate select:** wb_regwrite=1, wb_rd=3, wb_wdata=0xABC, id_rs1=3, id_rdata1=0, id_alusrc=1, id_imm=0xFFFF_FFFF_FFFF_FFF0, no MEM match → next cycle ex_in1=0xABC and ex_in2=0xFFFF_FFFF_FFFF_FFF0.
- **Flush with hazard:** same load-use setup as above with flush=1 → stall_if_id=0. Next cycle: ex_valid=0, ex_regwrite=0 and stall_count is unchanged.
